matmul_seq_ctrl: RTL and testbench
==================================

Name: matmul_seq_ctrl

Overview:
Parametrised sequencing controller for the matrix-multiplier datapath, computing R = A(M×K) · B(K×P) with independently sized dimensions. It owns all loop counters and generates:
- write and read addresses for the A, B and R memories;
- control for the external multiply-accumulate unit;
- ready/valid handshakes for operand input and result output.

It sits between the host stream interface and the storage/MAC datapath. All memories have combinational (same-cycle) read.

Parameters:
M, 2, rows of A and of R (>=1)
K, 2, columns of A = rows of B (>=1)
P, 2, columns of B and of R (>=1)
AW_A, $clog2(M*K) min 1, A address width
AW_B, $clog2(K*P) min 1, B address width
AW_R, $clog2(M*P) min 1, R address width

Ports:
clk  in  1  clock, all state changes on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a job; sampled only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the final result handshake
in_valid  in  1  operand word available (A words first, then B, each row-major)
in_ready  out  1  controller accepts an operand this cycle
a_we  out  1  A memory write enable
a_waddr  out  AW_A  A write address
b_we  out  1  B memory write enable
b_waddr  out  AW_B  B write address
a_raddr  out  AW_A  A read address during COMPUTE
b_raddr  out  AW_B  B read address during COMPUTE
mac_en  out  1  MAC consumes A/B read data this cycle
mac_clr  out  1  with mac_en: load product instead of accumulating
r_we  out  1  R memory write enable (MAC result)
r_addr  out  AW_R  R write address in SAVE; R read address in DELIVER
out_valid  out  1  R data (combinational read at r_addr) valid
out_ready  in  1  consumer accepts result
out_last  out  1  with out_valid: final result element

Behaviour:
- States: IDLE, LOAD_A, LOAD_B, COMPUTE, SAVE, DELIVER. Counters: i (0..M-1), j (0..P-1), k (0..K-1), plus a load index.
- Reset: state IDLE, all counters 0. Every output 0, address outputs 0.
- IDLE: in_ready=0. start=1 → LOAD_A next cycle with counters cleared. start while busy is ignored.
- LOAD_A:
  - in_ready=1; a_we = in_valid; a_waddr = load index.
  - The index advances only on a handshake (in_valid & in_ready).
  - The handshake at index M*K-1 → LOAD_B, index cleared.
  - No handshake: hold state and index (stalls of any length are legal).
- LOAD_B: same rules with b_we/b_waddr over K*P words → COMPUTE with i=j=k=0.
- COMPUTE:
  - One MAC cycle per k; no stalls.
  - a_raddr = i*K+k; b_raddr = k*P+j; mac_en=1; mac_clr = (k==0).
  - k==K-1 → SAVE.
- SAVE (1 cycle):
  - r_we=1, r_addr = i*P+j; k cleared.
  - Advance j; on wrap to 0, advance i. Loop order: j inner, i outer.
  - Last element (i=M-1, j=P-1) → DELIVER with the index at 0; otherwise → COMPUTE.
- Compute latency: exactly M*P*(K+1) cycles from entering COMPUTE to entering DELIVER.
- DELIVER:
  - out_valid=1; r_addr = delivery index; out_last = (index==M*P-1).
  - The index advances only on out_ready. r_addr must stay stable while out_valid & !out_ready.
  - Handshake with out_last → IDLE, with done=1 in that IDLE cycle only.
- Address arithmetic: use incrementing/stride counters (no multipliers required). Values must equal the formulas above and stay within AW_*.
- Degenerate sizes:
  - K=1: every COMPUTE cycle asserts mac_clr.
  - M=P=K=1: load 1+1 words, 1 COMPUTE, 1 SAVE, 1 output.
- rst during any state: next cycle IDLE, all outputs 0, any partial job discarded, no done pulse.
- in_valid outside LOAD_A/LOAD_B: ignored; in_ready=0, no write.

Test Plan:
- Reset/idle: rst=1 two cycles, then idle 5 cycles with in_valid=1 → all outputs 0, no writes, busy=0.
- Full job, M=2, K=3, P=2: A=1..6, B=7..12 with no stalls; out_ready=1 → a_waddr 0..5 then b_waddr 0..5; COMPUTE+SAVE spans 16 cycles; R stream 58,64,139,154 with out_last on the 4th; done pulses once.
- Input stalls: in_valid toggled 1,0,0,1 pattern through loading → writes only on handshakes, addresses gap-free 0..5, same result.
- Output backpressure: out_ready low 3 cycles on element 1 → r_addr held at 1, out_valid held, no element skipped or duplicated.
- Degenerate M=K=P=1: A=3, B=5 → one mac_en with mac_clr, r_we at r_addr 0, single output 15 with out_last.
- Mid-job reset/start: start pulsed during COMPUTE is ignored; rst asserted in COMPUTE → IDLE next cycle, busy=0, no done; a fresh job then completes correctly.

Source files
------------

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: sequencing controller for R = A(MxK) * B(KxP).
// Owns the loop counters, drives the A/B/R memory addresses, the external
// MAC unit controls, and the operand-in / result-out handshakes.
//
// Handshake rule (both streams): a word transfers on a rising edge where valid
// and ready are both high. in_ready depends only on state, never on in_valid.
// While out_valid is high and out_ready low, r_addr (and therefore the
// combinationally read R data) is held stable until the transfer happens.
module matmul_seq_ctrl #(
  parameter int M    = 2,
  parameter int K    = 2,
  parameter int P    = 2,
  parameter int AW_A = (M * K > 1) ? $clog2(M * K) : 1,
  parameter int AW_B = (K * P > 1) ? $clog2(K * P) : 1,
  parameter int AW_R = (M * P > 1) ? $clog2(M * P) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            a_we,
  output logic [AW_A-1:0] a_waddr,
  output logic            b_we,
  output logic [AW_B-1:0] b_waddr,
  output logic [AW_A-1:0] a_raddr,
  output logic [AW_B-1:0] b_raddr,
  output logic            mac_en,
  output logic            mac_clr,
  output logic            r_we,
  output logic [AW_R-1:0] r_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic [2:0]      dbg_state
);

  localparam int IW  = (M > 1) ? $clog2(M) : 1;
  localparam int JW  = (P > 1) ? $clog2(P) : 1;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int LW0 = (AW_A > AW_B) ? AW_A : AW_B;
  localparam int LW  = (LW0 > AW_R) ? LW0 : AW_R;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_COMPUTE = 3'd3,
    S_SAVE    = 3'd4,
    S_DELIVER = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_i;
  logic [JW-1:0]   r_j;
  logic [KW-1:0]   r_k;
  logic [LW-1:0]   r_idx;     // load index in LOAD_A/B, delivery index in DELIVER
  logic [AW_A-1:0] r_a_base;  // i*K
  logic [AW_A-1:0] r_a_rd;    // i*K + k
  logic [AW_B-1:0] r_b_rd;    // k*P + j
  logic [AW_R-1:0] r_res;     // i*P + j (row-major result position)
  logic            r_done;

  logic w_load_a_end;
  logic w_load_b_end;
  logic w_k_last;
  logic w_j_last;
  logic w_elem_last;
  logic w_out_last;

  assign w_load_a_end = (r_idx == LW'(M * K - 1));
  assign w_load_b_end = (r_idx == LW'(K * P - 1));
  assign w_out_last   = (r_idx == LW'(M * P - 1));
  assign w_k_last     = (r_k == KW'(K - 1));
  assign w_j_last     = (r_j == JW'(P - 1));
  assign w_elem_last  = w_j_last && (r_i == IW'(M - 1));

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign dbg_state = r_state;

  // State register and the one-cycle done pulse after the final result transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DELIVER) && out_ready && w_out_last;
    end
  end

  // Loop counters and stride-based address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_idx    <= '0;
      r_a_base <= '0;
      r_a_rd   <= '0;
      r_b_rd   <= '0;
      r_res    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_idx    <= '0;
            r_a_base <= '0;
            r_a_rd   <= '0;
            r_b_rd   <= '0;
            r_res    <= '0;
          end
        end
        S_LOAD_A: begin
          if (in_valid) r_idx <= w_load_a_end ? '0 : r_idx + LW'(1);
        end
        S_LOAD_B: begin
          if (in_valid) begin
            if (w_load_b_end) begin
              r_idx    <= '0;
              r_i      <= '0;
              r_j      <= '0;
              r_k      <= '0;
              r_a_base <= '0;
              r_a_rd   <= '0;
              r_b_rd   <= '0;
              r_res    <= '0;
            end else begin
              r_idx <= r_idx + LW'(1);
            end
          end
        end
        S_COMPUTE: begin
          // Values left after the last k are overwritten in SAVE.
          r_k    <= r_k + KW'(1);
          r_a_rd <= r_a_rd + AW_A'(1);
          r_b_rd <= r_b_rd + AW_B'(P);
        end
        S_SAVE: begin
          r_k   <= '0;
          r_res <= r_res + AW_R'(1);
          if (w_j_last) begin
            r_j      <= '0;
            r_i      <= r_i + IW'(1);
            r_a_base <= r_a_base + AW_A'(K);
            r_a_rd   <= r_a_base + AW_A'(K);
            r_b_rd   <= '0;
          end else begin
            r_j    <= r_j + JW'(1);
            r_a_rd <= r_a_base;
            r_b_rd <= AW_B'(r_j) + AW_B'(1);
          end
        end
        S_DELIVER: begin
          if (out_ready) r_idx <= w_out_last ? '0 : r_idx + LW'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state and all datapath/handshake outputs, decoded from state.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    a_we      = 1'b0;
    a_waddr   = '0;
    b_we      = 1'b0;
    b_waddr   = '0;
    a_raddr   = '0;
    b_raddr   = '0;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    r_we      = 1'b0;
    r_addr    = '0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD_A;
      end
      S_LOAD_A: begin
        in_ready = 1'b1;
        a_we     = in_valid;
        a_waddr  = r_idx[AW_A-1:0];
        if (in_valid && w_load_a_end) w_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        in_ready = 1'b1;
        b_we     = in_valid;
        b_waddr  = r_idx[AW_B-1:0];
        if (in_valid && w_load_b_end) w_next = S_COMPUTE;
      end
      S_COMPUTE: begin
        a_raddr = r_a_rd;
        b_raddr = r_b_rd;
        mac_en  = 1'b1;
        mac_clr = (r_k == '0);
        if (w_k_last) w_next = S_SAVE;
      end
      S_SAVE: begin
        r_we   = 1'b1;
        r_addr = r_res;
        w_next = w_elem_last ? S_DELIVER : S_COMPUTE;
      end
      S_DELIVER: begin
        out_valid = 1'b1;
        r_addr    = r_idx[AW_R-1:0];
        out_last  = w_out_last;
        if (out_ready && w_out_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: a 2x3x2 instance with a behavioural memory/MAC
// datapath around it, plus a 1x1x1 instance for the degenerate case.
module tb_matmul_seq_ctrl;
  localparam int M = 2, K = 3, P = 2;
  localparam int AWA = 3, AWB = 3, AWR = 2;
  localparam int NA = M * K, NB = K * P, NR = M * P;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- 2x3x2 instance ----------------
  logic start, in_valid, out_ready;
  logic busy, done, in_ready, a_we, b_we, mac_en, mac_clr, r_we, out_valid, out_last;
  logic [AWA-1:0] a_waddr, a_raddr;
  logic [AWB-1:0] b_waddr, b_raddr;
  logic [AWR-1:0] r_addr;
  logic [2:0]     dbg_state;
  logic [15:0]    in_data;

  matmul_seq_ctrl #(.M(M), .K(K), .P(P)) u_dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_we(a_we), .a_waddr(a_waddr), .b_we(b_we), .b_waddr(b_waddr),
    .a_raddr(a_raddr), .b_raddr(b_raddr), .mac_en(mac_en), .mac_clr(mac_clr),
    .r_we(r_we), .r_addr(r_addr), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .dbg_state(dbg_state)
  );

  logic [15:0] a_mem [0:NA-1];
  logic [15:0] b_mem [0:NB-1];
  logic [31:0] r_mem [0:NR-1];
  logic [31:0] acc;
  logic [31:0] out_data;
  always @(posedge clk) begin
    if (a_we) a_mem[a_waddr] <= in_data;
    if (b_we) b_mem[b_waddr] <= in_data;
    if (mac_en) acc <= (mac_clr ? 32'd0 : acc) + 32'(a_mem[a_raddr]) * 32'(b_mem[b_raddr]);
    if (r_we) r_mem[r_addr] <= acc;
  end
  assign out_data = r_mem[r_addr];

  // ---------------- 1x1x1 instance ----------------
  logic t_start, t_in_valid, t_out_ready;
  logic t_busy, t_done, t_in_ready, t_a_we, t_b_we, t_mac_en, t_mac_clr, t_r_we, t_out_valid, t_out_last;
  logic t_a_waddr, t_a_raddr, t_b_waddr, t_b_raddr, t_r_addr;
  logic [2:0]  t_dbg_state;
  logic [15:0] t_in_data;

  matmul_seq_ctrl #(.M(1), .K(1), .P(1)) u_tiny (
    .clk(clk), .rst(rst), .start(t_start), .busy(t_busy), .done(t_done),
    .in_valid(t_in_valid), .in_ready(t_in_ready),
    .a_we(t_a_we), .a_waddr(t_a_waddr), .b_we(t_b_we), .b_waddr(t_b_waddr),
    .a_raddr(t_a_raddr), .b_raddr(t_b_raddr), .mac_en(t_mac_en), .mac_clr(t_mac_clr),
    .r_we(t_r_we), .r_addr(t_r_addr), .out_valid(t_out_valid), .out_ready(t_out_ready),
    .out_last(t_out_last), .dbg_state(t_dbg_state)
  );

  logic [15:0] t_a_mem [0:1];
  logic [15:0] t_b_mem [0:1];
  logic [31:0] t_r_mem [0:1];
  logic [31:0] t_acc;
  logic [31:0] t_out_data;
  always @(posedge clk) begin
    if (t_a_we) t_a_mem[t_a_waddr] <= t_in_data;
    if (t_b_we) t_b_mem[t_b_waddr] <= t_in_data;
    if (t_mac_en) t_acc <= (t_mac_clr ? 32'd0 : t_acc) + 32'(t_a_mem[t_a_raddr]) * 32'(t_b_mem[t_b_raddr]);
    if (t_r_we) t_r_mem[t_r_addr] <= t_acc;
  end
  assign t_out_data = t_r_mem[t_r_addr];

  // ---------------- monitor (samples mid-cycle) ----------------
  int cyc = 0;
  int mac_n = 0, clr_n = 0, done_n = 0, stray_n = 0;
  int first_mac_cyc = -1, first_ov_cyc = -1;
  int a_wa_q[$];
  int b_wa_q[$];
  int r_wa_q[$];
  always @(negedge clk) begin
    if (a_we) a_wa_q.push_back(int'(a_waddr));
    if (b_we) b_wa_q.push_back(int'(b_waddr));
    if ((a_we || b_we) && !(in_valid && in_ready)) stray_n++;
    if (mac_en) begin
      mac_n++;
      if (mac_clr) clr_n++;
      if (first_mac_cyc < 0) first_mac_cyc = cyc;
    end
    if (r_we) r_wa_q.push_back(int'(r_addr));
    if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
    if (done) done_n++;
    cyc++;
  end

  // ---------------- scoreboard / reference model ----------------
  int n_chk = 0, n_pass = 0;
  logic [15:0] a_v [NA];
  logic [15:0] b_v [NB];
  logic [31:0] exp_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  // Fill operand matrices and compute the expected row-major R stream.
  task automatic gen_job(input bit directed);
    logic [31:0] s;
    for (int n = 0; n < NA; n++) a_v[n] = directed ? 16'(n + 1) : 16'($urandom_range(0, 255));
    for (int n = 0; n < NB; n++) b_v[n] = directed ? 16'(n + 7) : 16'($urandom_range(0, 255));
    exp_q.delete();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++) begin
        s = 0;
        for (int kk = 0; kk < K; kk++) s += 32'(a_v[i * K + kk]) * 32'(b_v[kk * P + j]);
        exp_q.push_back(s);
      end
  endtask

  task automatic clear_logs();
    a_wa_q.delete(); b_wa_q.delete(); r_wa_q.delete();
    mac_n = 0; clr_n = 0; done_n = 0; stray_n = 0;
    first_mac_cyc = -1; first_ov_cyc = -1;
  endtask

  // Starts a job (called at posedge+1) and feeds A then B.
  // stall_mode: 0 none, 1 valid pattern 1,0,0,1, 2 random.
  task automatic start_and_load(input int stall_mode);
    int idx, budget, pat;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; budget = 0; pat = 0;
    while (idx < NA + NB && budget < 400) begin
      case (stall_mode)
        0: in_valid = 1'b1;
        1: in_valid = (pat % 4 == 0) || (pat % 4 == 3);
        default: in_valid = ($urandom_range(0, 99) >= 40);
      endcase
      pat++;
      in_data = (idx < NA) ? a_v[idx] : b_v[idx - NA];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0;
    n_chk++;
    if (idx != NA + NB) $display("FAIL load_timeout: accepted %0d words, required %0d", idx, NA + NB);
    else n_pass++;
  endtask

  // One complete job with checks. bp_mode: 0 always ready, 1 hold element 1 for 3 cycles, 2 random.
  task automatic run_job(input bit directed, input int stall_mode, input int bp_mode, input string tag);
    int got, budget, low_n;
    logic hold_chk;
    logic [AWR-1:0] held;
    gen_job(directed);
    clear_logs();
    start_and_load(stall_mode);
    got = 0; budget = 0; low_n = 0; hold_chk = 1'b0; held = '0;
    while (got < NR && budget < 400) begin
      case (bp_mode)
        0: out_ready = 1'b1;
        1: out_ready = !(got == 1 && low_n < 3);
        default: out_ready = ($urandom_range(0, 99) >= 50);
      endcase
      @(negedge clk);
      if (hold_chk) begin
        n_chk++;
        if ({out_valid, r_addr} !== {1'b1, held})
          $display("FAIL %s hold: out_valid=%0b r_addr=%0d, required 1 and %0d", tag, out_valid, r_addr, held);
        else n_pass++;
      end
      hold_chk = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          n_chk++;
          if (out_data !== exp_q[got] || r_addr !== AWR'(got) || out_last !== (got == NR - 1))
            $display("FAIL %s elem%0d: data=%0d addr=%0d last=%0b, required %0d %0d %0b",
                     tag, got, out_data, r_addr, out_last, exp_q[got], got, (got == NR - 1));
          else n_pass++;
          got++;
        end else begin
          held = r_addr;
          hold_chk = 1'b1;
          if (got == 1) low_n++;
        end
      end
      @(posedge clk); #1;
      budget++;
    end
    out_ready = 1'b0;
    n_chk++;
    if (got != NR) $display("FAIL %s deliver_timeout: got %0d results, required %0d", tag, got, NR);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({done, busy} !== 2'b10) $display("FAIL %s done_pulse: done=%0b busy=%0b, required 1 0", tag, done, busy);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0) $display("FAIL %s done_width: done=%0b, required 0", tag, done);
    else n_pass++;
    // Logged control activity over the whole job.
    n_chk++;
    if (a_wa_q.size() != NA || b_wa_q.size() != NB || r_wa_q.size() != NR)
      $display("FAIL %s write_counts: a=%0d b=%0d r=%0d, required %0d %0d %0d",
               tag, a_wa_q.size(), b_wa_q.size(), r_wa_q.size(), NA, NB, NR);
    else n_pass++;
    for (int n = 0; n < a_wa_q.size(); n++) begin
      n_chk++;
      if (a_wa_q[n] != n) $display("FAIL %s a_waddr[%0d]: got %0d, required %0d", tag, n, a_wa_q[n], n);
      else n_pass++;
    end
    for (int n = 0; n < b_wa_q.size(); n++) begin
      n_chk++;
      if (b_wa_q[n] != n) $display("FAIL %s b_waddr[%0d]: got %0d, required %0d", tag, n, b_wa_q[n], n);
      else n_pass++;
    end
    for (int n = 0; n < r_wa_q.size(); n++) begin
      n_chk++;
      if (r_wa_q[n] != n) $display("FAIL %s r_waddr[%0d]: got %0d, required %0d", tag, n, r_wa_q[n], n);
      else n_pass++;
    end
    n_chk++;
    if (mac_n != NR * K || clr_n != NR || stray_n != 0 || done_n != 1)
      $display("FAIL %s mac_done: mac=%0d clr=%0d stray=%0d done=%0d, required %0d %0d 0 1",
               tag, mac_n, clr_n, stray_n, done_n, NR * K, NR);
    else n_pass++;
    n_chk++;
    if (first_ov_cyc - first_mac_cyc != NR * (K + 1))
      $display("FAIL %s latency: %0d cycles, required %0d", tag, first_ov_cyc - first_mac_cyc, NR * (K + 1));
    else n_pass++;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [23:0] obs;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    t_start = 1'b0; t_in_valid = 1'b0; t_out_ready = 1'b0; t_in_data = '0;
    @(posedge clk); #1;
    @(negedge clk);
    obs = {busy, done, in_ready, a_we, b_we, mac_en, mac_clr, r_we, out_valid, out_last,
           a_waddr, b_waddr, a_raddr, b_raddr, r_addr};
    n_chk++;
    if (obs !== '0 || t_busy !== 1'b0) $display("FAIL reset_state: outputs=%h tiny_busy=%0b, required 0 0", obs, t_busy);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1;
    clear_logs();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      obs = {busy, done, in_ready, a_we, b_we, mac_en, mac_clr, r_we, out_valid, out_last,
             a_waddr, b_waddr, a_raddr, b_raddr, r_addr};
      n_chk++;
      if (obs !== '0) $display("FAIL idle_cycle%0d: outputs=%h, required 0", c, obs);
      else n_pass++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_chk++;
    if (a_wa_q.size() + b_wa_q.size() != 0) $display("FAIL idle_writes: %0d writes, required 0", a_wa_q.size() + b_wa_q.size());
    else n_pass++;
  endtask

  task automatic test_full_job();      run_job(1'b1, 0, 0, "full_job");     endtask
  task automatic test_input_stalls();  run_job(1'b1, 1, 0, "input_stalls"); endtask
  task automatic test_backpressure();  run_job(1'b1, 0, 1, "backpressure"); endtask

  task automatic test_random_jobs();
    for (int n = 0; n < 4; n++) run_job(1'b0, 2, 2, "random_job");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 2; n++) run_job(1'b0, 0, 0, "back_to_back");
  endtask

  task automatic test_degenerate(input logic [15:0] av, input logic [15:0] bv);
    t_start = 1'b1;
    @(posedge clk); #1;
    t_start = 1'b0; t_in_valid = 1'b1; t_in_data = av;
    @(negedge clk);
    n_chk++;
    if ({t_in_ready, t_a_we, t_a_waddr, t_b_we, t_mac_en} !== 5'b11000)
      $display("FAIL deg_load_a: rdy/awe/addr/bwe/mac=%b, required 11000", {t_in_ready, t_a_we, t_a_waddr, t_b_we, t_mac_en});
    else n_pass++;
    @(posedge clk); #1;
    t_in_data = bv;
    @(negedge clk);
    n_chk++;
    if ({t_in_ready, t_a_we, t_b_we, t_b_waddr, t_mac_en} !== 5'b10100)
      $display("FAIL deg_load_b: rdy/awe/bwe/addr/mac=%b, required 10100", {t_in_ready, t_a_we, t_b_we, t_b_waddr, t_mac_en});
    else n_pass++;
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({t_mac_en, t_mac_clr, t_a_raddr, t_b_raddr, t_r_we, t_out_valid} !== 6'b110000)
      $display("FAIL deg_compute: mac/clr/ara/bra/rwe/ov=%b, required 110000", {t_mac_en, t_mac_clr, t_a_raddr, t_b_raddr, t_r_we, t_out_valid});
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if ({t_mac_en, t_r_we, t_r_addr, t_out_valid} !== 4'b0100)
      $display("FAIL deg_save: mac/rwe/raddr/ov=%b, required 0100", {t_mac_en, t_r_we, t_r_addr, t_out_valid});
    else n_pass++;
    @(posedge clk); #1;
    t_out_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({t_out_valid, t_out_last} !== 2'b11 || t_out_data !== 32'(av) * 32'(bv))
      $display("FAIL deg_deliver: ov=%0b last=%0b data=%0d, required 1 1 %0d", t_out_valid, t_out_last, t_out_data, 32'(av) * 32'(bv));
    else n_pass++;
    @(posedge clk); #1;
    t_out_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({t_done, t_busy} !== 2'b10) $display("FAIL deg_done: done=%0b busy=%0b, required 1 0", t_done, t_busy);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (t_done !== 1'b0) $display("FAIL deg_done_width: done=%0b, required 0", t_done);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_job_reset();
    int budget;
    logic [23:0] obs;
    gen_job(1'b0);
    clear_logs();
    start_and_load(0);
    budget = 0;
    @(negedge clk);
    while (!mac_en && budget < 50) begin
      @(posedge clk); #1;
      @(negedge clk);
      budget++;
    end
    n_chk++;
    if (mac_en !== 1'b1) $display("FAIL midrst_reach_compute: mac_en=%0b, required 1", mac_en);
    else n_pass++;
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({mac_en, in_ready, busy} !== 3'b101) $display("FAIL midrst_start_ignored: mac/rdy/busy=%b, required 101", {mac_en, in_ready, busy});
    else n_pass++;
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    done_n = 0;
    @(negedge clk);
    obs = {busy, done, in_ready, a_we, b_we, mac_en, mac_clr, r_we, out_valid, out_last,
           a_waddr, b_waddr, a_raddr, b_raddr, r_addr};
    n_chk++;
    if (obs !== '0) $display("FAIL midrst_idle: outputs=%h, required 0", obs);
    else n_pass++;
    repeat (6) begin @(posedge clk); #1; end
    n_chk++;
    if (done_n != 0) $display("FAIL midrst_no_done: %0d done cycles, required 0", done_n);
    else n_pass++;
    run_job(1'b0, 0, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_input_stalls();
    test_backpressure();
    test_degenerate(16'd3, 16'd5);
    test_degenerate(16'($urandom_range(0, 1000)), 16'($urandom_range(0, 1000)));
    test_mid_job_reset();
    test_back_to_back();
    test_random_jobs();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
